// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO pixel reader: buffer occupancy encoding
// and the wrap-around helper used by the position counters.
package fifo_reader_pkg;

    localparam int unsigned OCC_W = 2;

    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    // Next counter value: increments, wrapping to 0 after reaching max.
    function automatic int unsigned pos_wrap(input int unsigned cnt, input int unsigned max);
        return (cnt >= max) ? 0 : cnt + 1;
    endfunction

endpackage

// File: rtl/fifo_pixel_reader_if.sv
// Bundle of the FIFO read-port signals and the outgoing pixel stream.
//   master : the reader (drives fifo_rd_en and the m_* stream outputs)
//   slave  : the environment (FIFO read port plus downstream consumer)
interface fifo_pixel_reader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 12
);
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;
    logic [CNT_W-1:0]  m_x;
    logic [CNT_W-1:0]  m_y;

    modport master (
        output fifo_rd_en, m_data, m_valid, m_sof, m_eol, m_eof, m_x, m_y,
        input  fifo_rd_data, fifo_rd_empty, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid, m_sof, m_eol, m_eof, m_x, m_y,
        output fifo_rd_data, fifo_rd_empty, m_ready
    );
endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry FIFO-order buffer between the FIFO read port and the stream.
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : write strobe, wr_data appended at the tail
//   pop      : remove the head entry
//   head     : registered head word
//   occ      : number of held words (0..2)
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] tail;

    // Write and pop may coincide; the caller's credit check keeps writes off a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= OCC_EMPTY;
        end else begin
            case ({wr_en, pop})
                2'b10: begin
                    if (occ == OCC_EMPTY) begin
                        head <= wr_data;
                        occ  <= OCC_ONE;
                    end else if (occ == OCC_ONE) begin
                        tail <= wr_data;
                        occ  <= OCC_FULL;
                    end
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - OCC_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged: head advances, new word lands behind it.
                    if (occ == OCC_ONE) begin
                        head <= wr_data;
                    end else begin
                        head <= tail;
                        tail <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pixel_reader.sv
// Drains a read-latency-1 synchronous FIFO into a valid/ready pixel stream
// at one pixel per cycle, tagging each beat with its frame position.
//   rd_clk, rd_rst : clock, asynchronous active-high reset (shared with the FIFO)
//   bus.fifo_*     : FIFO read port (rd_en out, rd_data/rd_empty in)
//   bus.m_*        : pixel stream (data/valid/flags/x/y out, ready in)
module fifo_pixel_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned c_DATA_WIDTH = 16,
    parameter int unsigned c_H_ACTIVE   = 640,
    parameter int unsigned c_V_ACTIVE   = 480,
    parameter int unsigned c_CNT_WIDTH  = 12
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    fifo_pixel_reader_if.master  bus
);

    localparam logic [c_CNT_WIDTH-1:0] X_LAST = c_CNT_WIDTH'(c_H_ACTIVE - 1);
    localparam logic [c_CNT_WIDTH-1:0] Y_LAST = c_CNT_WIDTH'(c_V_ACTIVE - 1);

    logic [OCC_W-1:0]        occ;
    logic [c_DATA_WIDTH-1:0] head;
    logic                    inflight;
    logic [c_CNT_WIDTH-1:0]  pos_x;
    logic [c_CNT_WIDTH-1:0]  pos_y;
    logic                    valid_c;
    logic                    pop_c;
    logic                    rd_en_c;
    logic [2:0]              credit_c;

    assign valid_c = (occ != OCC_EMPTY);
    assign pop_c   = valid_c & bus.m_ready;

    // Words held plus the one arriving, minus the one leaving; must stay below 2
    // so the word requested now always has a slot when it lands next cycle.
    assign credit_c = 3'(occ) + 3'(inflight) - 3'(pop_c);
    assign rd_en_c  = !bus.fifo_rd_empty & !rd_rst & (credit_c < 3'd2);

    // Marks that fifo_rd_data carries a word this cycle.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en_c;
        end
    end

    fifo_reader_skid #(
        .DATA_W (c_DATA_WIDTH)
    ) u_skid (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .wr_en   (inflight),
        .wr_data (bus.fifo_rd_data),
        .pop     (pop_c),
        .head    (head),
        .occ     (occ)
    );

    // Position of the head beat; advances only when a beat is accepted.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (pop_c) begin
            pos_x <= c_CNT_WIDTH'(pos_wrap(32'(pos_x), c_H_ACTIVE - 1));
            if (pos_x == X_LAST) begin
                pos_y <= c_CNT_WIDTH'(pos_wrap(32'(pos_y), c_V_ACTIVE - 1));
            end
        end
    end

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_valid    = valid_c;
    assign bus.m_data     = head;
    assign bus.m_x        = pos_x;
    assign bus.m_y        = pos_y;
    assign bus.m_sof      = valid_c & (pos_x == '0) & (pos_y == '0);
    assign bus.m_eol      = valid_c & (pos_x == X_LAST);
    assign bus.m_eof      = valid_c & (pos_x == X_LAST) & (pos_y == Y_LAST);

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Self-checking bench for fifo_pixel_reader with H=4, V=2 and a behavioural
// read-latency-1 FIFO model fed from a queue.
module tb_fifo_pixel_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 12;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    typedef struct {
        logic [DW-1:0] din;
        beat_t         exp;
    } vec_t;

    logic rd_clk = 1'b0;
    logic rd_rst;

    always #5 rd_clk = ~rd_clk;

    fifo_pixel_reader_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fifo_pixel_reader #(
        .c_DATA_WIDTH (DW),
        .c_H_ACTIVE   (4),
        .c_V_ACTIVE   (2),
        .c_CNT_WIDTH  (CW)
    ) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    logic [DW-1:0] fifo_q[$];
    beat_t         acc_q[$];
    beat_t         prev_beat;
    logic          prev_stall;
    int            n_cmp;
    int            n_bad;
    int            cyc;
    vec_t          tbl[8];

    // FIFO model: data appears the cycle after fifo_rd_en, empty is registered.
    initial begin
        bus.fifo_rd_empty = 1'b1;
        bus.fifo_rd_data  = '0;
        forever begin
            @(posedge rd_clk);
            if (bus.fifo_rd_en) begin
                if (fifo_q.size() != 0) bus.fifo_rd_data <= fifo_q.pop_front();
                else                    bus.fifo_rd_data <= 16'hDEAD;
            end
            bus.fifo_rd_empty <= (fifo_q.size() == 0);
        end
    end

    function automatic beat_t mk(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] x,
                                 input logic [CW-1:0] y, input logic s, input logic e,
                                 input logic f);
        beat_t b;
        b.valid = v; b.data = d; b.x = x; b.y = y; b.sof = s; b.eol = e; b.eof = f;
        return b;
    endfunction

    function automatic beat_t snap();
        return mk(bus.m_valid, bus.m_data, bus.m_x, bus.m_y, bus.m_sof, bus.m_eol, bus.m_eof);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive m_ready after the falling edge, then sample and monitor.
    task automatic step(input logic rdy);
        beat_t b;
        @(negedge rd_clk);
        bus.m_ready = rdy;
        #1;
        cyc++;
        b = snap();
        check("rd_en_while_empty", 64'(bus.fifo_rd_en & bus.fifo_rd_empty), 64'd0);
        check("occ_bound", 64'(dut.occ <= 2'd2), 64'd1);
        if (prev_stall) check("stall_hold", 64'(b), 64'(prev_beat));
        prev_stall = b.valid & ~rdy;
        prev_beat  = b;
        if (b.valid && rdy) acc_q.push_back(b);
    endtask

    task automatic drain(input int n, input int budget);
        int c = 0;
        while (acc_q.size() < n && c < budget) begin
            step(1'b1);
            c++;
        end
        check("drain_timeout", 64'(acc_q.size() >= n), 64'd1);
    endtask

    initial begin
        int   t0;
        int   n;
        int   fed;
        logic r;

        n_cmp = 0; n_bad = 0; cyc = 0;
        prev_stall = 1'b0; prev_beat = '0;
        rd_rst = 1'b1;
        bus.m_ready = 1'b0;

        tbl[0] = '{din: 16'h0001, exp: mk(1'b1, 16'h0001, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0)};
        tbl[1] = '{din: 16'h0002, exp: mk(1'b1, 16'h0002, 12'd1, 12'd0, 1'b0, 1'b0, 1'b0)};
        tbl[2] = '{din: 16'h0003, exp: mk(1'b1, 16'h0003, 12'd2, 12'd0, 1'b0, 1'b0, 1'b0)};
        tbl[3] = '{din: 16'h0004, exp: mk(1'b1, 16'h0004, 12'd3, 12'd0, 1'b0, 1'b1, 1'b0)};
        tbl[4] = '{din: 16'h0005, exp: mk(1'b1, 16'h0005, 12'd0, 12'd1, 1'b0, 1'b0, 1'b0)};
        tbl[5] = '{din: 16'h0006, exp: mk(1'b1, 16'h0006, 12'd1, 12'd1, 1'b0, 1'b0, 1'b0)};
        tbl[6] = '{din: 16'h0007, exp: mk(1'b1, 16'h0007, 12'd2, 12'd1, 1'b0, 1'b0, 1'b0)};
        tbl[7] = '{din: 16'h0008, exp: mk(1'b1, 16'h0008, 12'd3, 12'd1, 1'b0, 1'b1, 1'b1)};

        // 1. Reset with a loaded FIFO, then first-word latency.
        for (int i = 0; i < 8; i++) fifo_q.push_back(tbl[i].din);
        for (int i = 0; i < 3; i++) step(1'b0);
        check("rst_fifo_loaded", 64'(bus.fifo_rd_empty), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_outputs", 64'(snap()), 64'd0);
        rd_rst = 1'b0;
        #1;
        check("rd_en_on_release", 64'(bus.fifo_rd_en), 64'd1);
        t0 = cyc;
        n = 0;
        while (!bus.m_valid && n < 10) begin
            step(1'b0);
            n++;
        end
        check("first_word_latency", 64'(cyc - t0), 64'd2);

        // 2. Full frame from the table, sustained with m_ready high.
        acc_q.delete();
        t0 = cyc;
        drain(8, 40);
        check("no_bubbles", 64'(cyc - t0), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_q.size()) check($sformatf("frame_beat%0d", i), 64'(acc_q[i]), 64'(tbl[i].exp));
        end
        step(1'b1);
        check("frame_wrap", 64'({bus.m_valid, bus.m_x, bus.m_y}), 64'd0);

        // 3. Random backpressure on a continuously fed FIFO.
        acc_q.delete();
        fed = 0;
        n = 0;
        while (acc_q.size() < 1000 && n < 20000) begin
            if (fed < 1000 && fifo_q.size() < 3) begin
                fifo_q.push_back(16'(fed * 7 + 3));
                fed++;
            end
            r = ($urandom_range(0, 99) < 30);
            step(r);
            n++;
        end
        check("bp_timeout", 64'(acc_q.size()), 64'd1000);
        for (int k = 0; k < acc_q.size() && k < 1000; k++) begin
            check($sformatf("bp_beat%0d", k), 64'({acc_q[k].data, acc_q[k].x, acc_q[k].y}),
                  64'({16'(k * 7 + 3), 12'(k % 4), 12'((k / 4) % 2)}));
        end

        // 4. m_ready drops the cycle after the first fifo_rd_en.
        acc_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(16'(16'h0A01 + i));
        n = 0;
        do begin
            step(1'b1);
            n++;
        end while (!bus.fifo_rd_en && n < 10);
        check("stall_setup_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        step(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check("stall_no_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        end
        check("stall_occ_full", 64'(dut.occ), 64'd2);
        check("stall_head", 64'({bus.m_valid, bus.m_data}), 64'({1'b1, 16'h0A01}));
        step(1'b1);
        check("rd_en_resume", 64'(bus.fifo_rd_en), 64'd1);
        drain(4, 20);
        for (int i = 0; i < acc_q.size() && i < 4; i++) begin
            check($sformatf("stall_order%0d", i), 64'({acc_q[i].data, acc_q[i].x}),
                  64'({16'(16'h0A01 + i), 12'(i)}));
        end

        // 5. FIFO runs dry after two words of a line, then resumes mid-line.
        acc_q.delete();
        fifo_q.push_back(16'h0B01);
        fifo_q.push_back(16'h0B02);
        for (int i = 0; i < 8; i++) step(1'b1);
        check("under_count", 64'(acc_q.size()), 64'd2);
        check("under_hold", 64'({bus.m_valid, bus.m_x, bus.m_y}), 64'({1'b0, 12'd2, 12'd1}));
        acc_q.delete();
        fifo_q.push_back(16'h00AA);
        drain(1, 10);
        if (acc_q.size() > 0)
            check("under_resume", 64'(acc_q[0]), 64'(mk(1'b1, 16'h00AA, 12'd2, 12'd1, 1'b0, 1'b0, 1'b0)));

        // 6. Reset while stalled at x=3, y=0.
        acc_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(16'(16'h0C01 + i));
        drain(4, 20);
        fifo_q.push_back(16'h0C05);
        fifo_q.push_back(16'h0C06);
        for (int i = 0; i < 5; i++) step(1'b0);
        check("pre_rst_beat", 64'(snap()), 64'(mk(1'b1, 16'h0C05, 12'd3, 12'd0, 1'b0, 1'b1, 1'b0)));
        rd_rst = 1'b1;
        fifo_q.delete();
        prev_stall = 1'b0;
        #1;
        check("rst_async_out", 64'(snap()), 64'd0);
        check("rst_async_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        step(1'b0);
        step(1'b0);
        check("rst_held_out", 64'(snap()), 64'd0);
        rd_rst = 1'b0;
        acc_q.delete();
        fifo_q.push_back(16'h0D01);
        drain(1, 10);
        if (acc_q.size() > 0)
            check("post_rst_sof", 64'(acc_q[0]), 64'(mk(1'b1, 16'h0D01, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
